// File: rtl/disp_ctrl_pkg.sv
// Shared constants for the display source select path: mux mode codes and
// the mode-change FSM state encoding.
package disp_ctrl_pkg;

    localparam logic [1:0] MODE_RGB   = 2'd0;
    localparam logic [1:0] MODE_GREY  = 2'd1;
    localparam logic [1:0] MODE_SOBEL = 2'd2;
    localparam logic [1:0] MODE_BLACK = 2'd3;

    typedef enum logic [1:0] {
        ST_SHOW  = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } disp_state_t;

    // Black is never a committed mode; the cycle wraps Sobel back to RGB.
    function automatic logic [1:0] next_mode_f(input logic [1:0] m);
        return (m == MODE_SOBEL) ? MODE_RGB : m + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-FF synchroniser, stability counter and a
// one-cycle registered pulse on each debounced rising edge.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_db_d;
    logic          r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], key};
            // r_sync[0] is the value r_sync[1] takes next, so a mismatch is a change
            if (r_sync[0] != r_sync[1]) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_db <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/display_mode_ctrl.sv
// Frame-synchronous display source sequencer with black-frame blanking.
// Optional auto-cycle via `define DISP_AUTOCYCLE_EN (adds auto_en port).
module display_mode_ctrl
    import disp_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLANK_FRAMES    = 1,
    parameter int AUTO_FRAMES     = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       vga_vs,
    output logic [1:0] sel,
    output logic [1:0] mode,
    output logic       busy
`ifdef DISP_AUTOCYCLE_EN
    ,
    input  logic       auto_en
`endif
);

    localparam logic [3:0] BLANK_LOAD = (BLANK_FRAMES > 0) ? 4'(BLANK_FRAMES - 1) : 4'd0;

    logic w_key_press;
    logic w_auto_press;
    logic w_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .press(w_key_press)
    );

    // vs is active-low; idle level is high so reset does not fake a frame edge.
    logic [1:0] r_vs_sync;
    logic       r_vs_d;
    logic       r_frame_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_sync    <= 2'b11;
            r_vs_d       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_sync    <= {r_vs_sync[0], vga_vs};
            r_vs_d       <= r_vs_sync[1];
            r_frame_tick <= r_vs_d & ~r_vs_sync[1];
        end
    end

    disp_state_t r_state, w_state_next;
    logic [1:0]  r_mode, w_mode_next;
    logic [1:0]  r_next_mode, w_next_mode_next;
    logic [1:0]  r_sel, w_sel_next;
    logic        r_busy, w_busy_next;
    logic [3:0]  r_blank_cnt, w_blank_cnt_next;

`ifdef DISP_AUTOCYCLE_EN
    localparam int            FW        = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_MAX = FW'(AUTO_FRAMES - 1);

    logic [FW-1:0] r_frame_cnt;

    assign w_auto_press = (r_state == ST_SHOW) && auto_en && r_frame_tick
                          && (r_frame_cnt == FRAME_MAX);

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_SHOW) || !auto_en) begin
            r_frame_cnt <= '0;
        end else if (r_frame_tick) begin
            r_frame_cnt <= (r_frame_cnt == FRAME_MAX) ? '0 : r_frame_cnt + 1'b1;
        end
    end
`else
    // AUTO_FRAMES is at least 1, so this is a constant 0 in the key-only build.
    assign w_auto_press = (AUTO_FRAMES < 1);
`endif

    assign w_press = w_key_press | w_auto_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SHOW;
            r_mode      <= MODE_RGB;
            r_next_mode <= MODE_RGB;
            r_sel       <= MODE_RGB;
            r_busy      <= 1'b0;
            r_blank_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_mode      <= w_mode_next;
            r_next_mode <= w_next_mode_next;
            r_sel       <= w_sel_next;
            r_busy      <= w_busy_next;
            r_blank_cnt <= w_blank_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_mode_next      = r_mode;
        w_next_mode_next = r_next_mode;
        w_blank_cnt_next = r_blank_cnt;

        case (r_state)
            ST_SHOW: begin
                // A tick coinciding with the press is deliberately not consumed.
                if (w_press) begin
                    w_next_mode_next = next_mode_f(r_mode);
                    w_state_next     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (r_frame_tick) begin
                    if (BLANK_FRAMES > 0) begin
                        w_state_next     = ST_BLANK;
                        w_blank_cnt_next = BLANK_LOAD;
                    end else begin
                        w_state_next = ST_SHOW;
                        w_mode_next  = r_next_mode;
                    end
                end
            end
            ST_BLANK: begin
                if (r_frame_tick) begin
                    if (r_blank_cnt == 4'd0) begin
                        w_state_next = ST_SHOW;
                        w_mode_next  = r_next_mode;
                    end else begin
                        w_blank_cnt_next = r_blank_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_SHOW;
            end
        endcase

        w_sel_next  = (w_state_next == ST_BLANK) ? MODE_BLACK : w_mode_next;
        w_busy_next = (w_state_next != ST_SHOW);
    end

    assign sel  = r_sel;
    assign mode = r_mode;
    assign busy = r_busy;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl: stimulus queues expected output
// tuples, a negedge monitor pops and compares on every output change.
module tb_display_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic       vga_vs = 1'b1;
    logic [1:0] sel;
    logic [1:0] mode;
    logic       busy;
`ifdef DISP_AUTOCYCLE_EN
    logic       auto_en = 1'b0;
`endif

    display_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLANK_FRAMES   (1),
        .AUTO_FRAMES    (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .vga_vs (vga_vs),
        .sel    (sel),
        .mode   (mode),
        .busy   (busy)
`ifdef DISP_AUTOCYCLE_EN
        ,
        .auto_en(auto_en)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // vs: 100-cycle period, low for 10 cycles, falls just after the phase-0 edge
    int vs_phase = 50;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            vs_phase = (vs_phase == 99) ? 0 : vs_phase + 1;
            vga_vs   = (vs_phase >= 10);
        end
    end

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] mode;
        logic       busy;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    out_t mon_cur;
    out_t mon_prev;
    out_t mon_exp;
    bit   mon_have_prev = 1'b0;
    int   last_commit_cyc = -1;

    always @(negedge clk) begin
        if (!rst) begin
            mon_cur = {sel, mode, busy};
            if (!mon_have_prev || mon_cur != mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got sel=%0d mode=%0d busy=%0d required no change",
                             cyc, sel, mode, busy);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_cur !== mon_exp) begin
                        errors++;
                        $display("FAIL output_seq cyc=%0d got sel=%0d mode=%0d busy=%0d required sel=%0d mode=%0d busy=%0d",
                                 cyc, sel, mode, busy, mon_exp.sel, mon_exp.mode, mon_exp.busy);
                    end else begin
                        $display("txn cyc=%0d sel=%0d mode=%0d busy=%0d ok", cyc, sel, mode, busy);
                    end
                end
                checks++;
                if (sel == 2'd3 && !busy) begin
                    errors++;
                    $display("FAIL black_outside_blank cyc=%0d got sel=3 busy=0 required busy=1", cyc);
                end
                if (mon_have_prev && mon_prev.busy && !mon_cur.busy) last_commit_cyc = cyc;
                mon_prev      = mon_cur;
                mon_have_prev = 1'b1;
            end
        end
    end

    task automatic push(input logic [1:0] s, input logic [1:0] m, input logic b);
        out_t e;
        e.sel  = s;
        e.mode = m;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Full change from mode m: pending, blanking, committed.
    task automatic push_change(input logic [1:0] m, input logic [1:0] n);
        push(m, m, 1'b1);
        push(2'd3, m, 1'b1);
        push(n, n, 1'b0);
    endtask

    task automatic press_key();
        @(posedge clk);
        #2 key = 1'b1;
        repeat (12) @(posedge clk);
        #2 key = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_black(input int budget, input string name);
        int n = 0;
        while (sel != 2'd3 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (sel != 2'd3) begin
            errors++;
            $display("FAIL %s_timeout got sel=%0d required 3", name, sel);
        end
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    int bounce_len[10] = '{1, 2, 3, 1, 3, 2, 1, 2, 3, 2};
    int c0;
    int c1;
    int n;

    initial begin
        // reset and idle
        push(2'd0, 2'd0, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        repeat (300) @(posedge clk);
        wait_drain(10, "reset");
        #2;
        check_val("idle_sel", sel, 0);
        check_val("idle_mode", mode, 0);
        check_val("idle_busy", busy, 0);

        // clean press 0 -> 1
        push_change(2'd0, 2'd1);
        press_key();
        wait_drain(400, "clean_press");

        // bouncing key, one advance 1 -> 2
        push_change(2'd1, 2'd2);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #2 key = (i % 2 == 0);
            repeat (bounce_len[i]) @(posedge clk);
        end
        #2 key = 1'b1;
        repeat (20) @(posedge clk);
        #2 key = 1'b0;
        wait_drain(400, "bounce");
        repeat (150) @(posedge clk);

        // wrap sequence 2 -> 0 -> 1 -> 2 -> 0
        push_change(2'd2, 2'd0);
        press_key();
        wait_drain(400, "wrap0");
        push_change(2'd0, 2'd1);
        press_key();
        wait_drain(400, "wrap1");
        push_change(2'd1, 2'd2);
        press_key();
        wait_drain(400, "wrap2");
        push_change(2'd2, 2'd0);
        press_key();
        wait_drain(400, "wrap3");

        // press coincident with frame_tick, then a dropped press during blanking
        push_change(2'd0, 2'd1);
        n = 0;
        @(posedge clk);
        #2;
        while (vs_phase != 96 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        c0 = cyc;
        key = 1'b1;
        repeat (12) @(posedge clk);
        #2 key = 1'b0;
        wait_black(300, "coinc_blank");
        repeat (20) @(posedge clk);
        press_key();
        wait_drain(400, "coinc");
        check_val("coinc_commit_cycle", last_commit_cyc, c0 + 208);
        repeat (300) @(posedge clk);

        // reset in the middle of blanking
        push(2'd1, 2'd1, 1'b1);
        push(2'd3, 2'd1, 1'b1);
        push(2'd0, 2'd0, 1'b0);
        press_key();
        wait_black(300, "rst_blank");
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_mid_sel", sel, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_mode", mode, 0);
        #1 rst = 1'b0;
        wait_drain(20, "rst_mid");
        push_change(2'd0, 2'd1);
        press_key();
        wait_drain(400, "after_rst");

`ifdef DISP_AUTOCYCLE_EN
        // auto-cycle: one advance every 3 + 2 frames
        push_change(2'd1, 2'd2);
        @(posedge clk);
        #2 auto_en = 1'b1;
        wait_drain(700, "auto1");
        c1 = last_commit_cyc;
        push_change(2'd2, 2'd0);
        wait_drain(700, "auto2");
        @(posedge clk);
        #2 auto_en = 1'b0;
        check_val("auto_period", last_commit_cyc - c1, 500);
        repeat (600) @(posedge clk);
`else
        c1 = 0;
        repeat (100) @(posedge clk);
`endif

        check_val("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_mode_ctrl.md
# display_mode_ctrl

Controller that sequences the VGA output-source select of the display mux (0 = camera RGB, 1 = greyscale, 2 = Sobel, 3 = black). A debounced pushbutton requests the next mode. The change is applied only at a frame boundary, with a configurable number of black frames in between, so the monitor never shows a torn or mixed frame. Sits between the board key/VGA timing generator and the `sw` select input of the output mux, replacing the direct switch connection.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: clk cycles the key must be stable (10 ms at 50 MHz); must be ≥ 2.
- `BLANK_FRAMES`, 1: black frames inserted during a mode change; 0 to 15.
- `AUTO_FRAMES`, 300: frames per mode in auto-cycle; must be ≥ 1. Only used with `DISP_AUTOCYCLE_EN`.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `key` in 1: raw pushbutton, active-high, asynchronous and bouncy.
- `vga_vs` in 1: VGA vertical sync, active-low, asynchronous to `clk`.
- `sel` out 2: registered select to the display mux.
- `mode` out 2: registered current committed mode, 0..2.
- `busy` out 1: registered; high while a change is pending or blanking.
- `auto_en` in 1: auto-cycle enable. Present only with `DISP_AUTOCYCLE_EN`.

## Operation
- Input conditioning:
  - `key` passes through a 2-FF synchroniser, then a debouncer. A counter clears on any change of the synced level. Once it reaches `DEBOUNCE_CYCLES-1`, the debounced level takes the synced value.
  - A rising edge of the debounced level produces a 1-cycle `press`.
  - `vga_vs` passes through a 2-FF synchroniser. Its falling edge produces a 1-cycle `frame_tick`.
- FSM states: SHOW, PEND, BLANK.
- SHOW:
  - `sel` = `mode`, `busy` = 0.
  - On `press`: `next_mode` = (`mode` == 2) ? 0 : `mode`+1, then go to PEND.
- PEND:
  - `sel` = `mode`, `busy` = 1.
  - On `frame_tick` with `BLANK_FRAMES` > 0: go to BLANK, `sel` = 3, load `blank_cnt` = `BLANK_FRAMES`-1.
  - On `frame_tick` with `BLANK_FRAMES` = 0: go to SHOW, `mode` = `next_mode`.
- BLANK:
  - `sel` = 3, `busy` = 1.
  - On `frame_tick` with `blank_cnt` = 0: go to SHOW, `mode` = `next_mode`, `sel` = `next_mode`.
  - On `frame_tick` with `blank_cnt` > 0: decrement `blank_cnt`.
- Presses arriving in PEND or BLANK are dropped, not queued.
- If `press` and `frame_tick` occur in the same cycle in SHOW, the press is taken and the tick is not consumed. The change then commits on a later tick.
- `sel` never takes the value 3 outside BLANK.
- Reset values:
  - `sel` = 0, `mode` = 0, `busy` = 0, state SHOW.
  - Debounce counter, `blank_cnt` and frame counter = 0.
  - Synchroniser flops = idle level: key 0, vs 1.
  - A reset during PEND or BLANK abandons the change; the next cycle shows mode 0.

## Timing
- Key path: `press` occurs 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles after a clean `key` rise.
- Frame path:
  - `frame_tick` is high in the 3rd cycle after the first edge that samples `vga_vs` low.
  - `sel` and `mode` update on the edge following `frame_tick`, i.e. within 4 edges of the vs fall.
- One change therefore spans exactly 1 + `BLANK_FRAMES` frame boundaries after the first tick following `press`.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `DISP_AUTOCYCLE_EN` defined:
  - Adds the `auto_en` port and a frame counter, which counts `frame_tick` in SHOW while `auto_en` = 1.
  - The counter clears on leaving SHOW and when `auto_en` = 0.
  - When the count reaches `AUTO_FRAMES`-1 and a tick arrives, an internal press is generated. It is ORed with the key press and takes the same FSM path.
- `DISP_AUTOCYCLE_EN` undefined: no port and no counter; behaviour is key-driven only.

## Structure
- Shared package `disp_ctrl_pkg` holds:
  - Mode constants: `MODE_RGB`=0, `MODE_GREY`=1, `MODE_SOBEL`=2, `MODE_BLACK`=3.
  - FSM state encoding: SHOW=0, PEND=1, BLANK=2.
  - The mux uses the same mode constants.
- One sub-module, `key_debounce`: synchroniser, counter and rising-edge pulse, parameterised by `DEBOUNCE_CYCLES`.
- The vs synchroniser and edge detect stay inline.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `BLANK_FRAMES`=1, `AUTO_FRAMES`=3, vs period 100 cycles.
- Reset, no activity → `sel`=0, `mode`=0, `busy`=0 held indefinitely.
- Clean key press → `busy`=1; at the first vs fall `sel`=3; at the second vs fall `sel`=1, `mode`=1, `busy`=0.
- Key bouncing with 1–3-cycle glitches for 20 cycles, then stable high → exactly one mode advance.
- Three full presses from mode 2 → sequence 0, then 1, then 2; a fourth press wraps to 0 and `sel` never shows 3 outside blanking.
- Second press during BLANK, plus a press coincident with `frame_tick` → second press ignored; the coincident press commits only after 2 further ticks.
- Reset asserted mid-BLANK → next cycle `sel`=0, `busy`=0. With `DISP_AUTOCYCLE_EN`, `auto_en`=1 → the mode advances every 3+2 frames.
